mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single simulation RAM port between instruction fetch (IF) and
//   load/store (LS) requesters in the multicycle core.
//   Serialises transactions through a small FSM, applies fixed LS priority with
//   an IF anti-starvation counter, and returns read data with a one-cycle ack.
//   Sits between if_stage/id_stage memory requests and the RAM model.
// PARAMETERS
//   ADDR_W      64  address width, both requesters and the RAM side
//   DATA_W      64  data and write-mask width
//   MEM_LAT     1   cycles from the ram_en cycle to ram_rdata valid; legal range >= 1
//   STARVE_MAX  4   consecutive LS grants allowed while if_req is pending
// PORTS
//   clock      in   1       system clock
//   reset      in   1       synchronous, active-high
//   if_req     in   1       fetch request; held with if_addr stable until if_ack
//   if_addr    in   ADDR_W  fetch address
//   if_ack     out  1       one-cycle pulse: fetch complete, if_rdata valid
//   if_rdata   out  DATA_W  fetched data; held until the next if_ack
//   ls_req     in   1       load/store request; held stable until ls_ack
//   ls_we      in   1       1 = store, 0 = load
//   ls_addr    in   ADDR_W  load/store address
//   ls_wdata   in   DATA_W  store data
//   ls_wmask   in   DATA_W  bit mask, 1 = write that bit
//   ls_ack     out  1       one-cycle pulse: LS complete; ls_rdata valid for loads
//   ls_rdata   out  DATA_W  load data; held until the next load ack
//   ram_en     out  1       RAM access strobe, high exactly one cycle per transaction
//   ram_we     out  1       RAM write enable, qualified by ram_en
//   ram_addr   out  ADDR_W  RAM address, registered
//   ram_wdata  out  DATA_W  RAM write data, registered
//   ram_wmask  out  DATA_W  RAM write mask, registered
//   ram_rdata  in   DATA_W  RAM read data, valid MEM_LAT cycles after the ram_en cycle
//   busy       out  1       FSM not in IDLE
//   owner      out  1       current or last grant: 0 = IF, 1 = LS
// BEHAVIOUR
//   Reset values: all outputs 0; FSM = IDLE; starve_cnt = 0; lat_cnt = 0.
//   FSM states and transitions:
//   - IDLE -> ISSUE when any req is high at the clock edge. Winner's addr, wdata,
//     wmask and we are latched into the ram_* registers and owner is set.
//   - ISSUE: ram_en = 1 for exactly one cycle; ram_we = latched we. ISSUE -> WAIT.
//   - WAIT: lat_cnt counts MEM_LAT cycles; the ISSUE cycle counts as cycle 0.
//     In cycle ISSUE+MEM_LAT, ram_rdata is captured into the owner's rdata
//     register (loads and fetches only; stores leave rdata unchanged). WAIT -> RESP.
//   - RESP: owner's ack = 1 for one cycle. RESP -> IDLE unconditionally
//     (one-cycle bubble).
//   Latency: first req-high cycle N gives ack in cycle N+2+MEM_LAT.
//     Back-to-back requests start every 3+MEM_LAT cycles.
//   Arbitration in IDLE:
//   - Both requesting -> LS wins, unless starve_cnt == STARVE_MAX, in which case IF wins.
//   - starve_cnt increments on each LS grant while if_req is high, saturating at
//     STARVE_MAX. It clears on an IF grant, or in any IDLE cycle with if_req low.
//   Handshake:
//   - Requesters hold req and payload until ack, and drop req in the cycle after ack.
//   - A req still high in the IDLE after RESP is treated as a new request.
//   - A req withdrawn before the grant is ignored.
//   - A req dropped after the grant does not abort the transaction; ack is still
//     pulsed and the requester discards it.
//   - Payload changes after the grant have no effect, because the payload is
//     latched at the grant.
//   ram_* address and data outputs hold their last values outside ISSUE;
//     only ram_en and ram_we return to 0.
//   Reset mid-transaction: FSM returns to IDLE on the next edge, ram_en and
//     both acks drop, rdata registers clear, and no ack is issued for the aborted access.
// TESTING
//   1. IF only: if_req=1, if_addr=0x80000000, RAM returns 0x00000013_00100093, MEM_LAT=1
//      -> ram_en high in cycle 1; if_ack pulses in cycle 3 with if_rdata=0x0000001300100093.
//   2. Simultaneous if_req and ls_req (load, 0x80001000) in IDLE -> LS granted first
//      (owner=1, ls_ack at cycle 3); IF granted next, if_ack at cycle 7.
//   3. Starvation: if_req held high while ls_req is re-asserted continuously
//      -> exactly 4 LS acks, then an IF grant; starve_cnt returns to 0.
//   4. Store: ls_we=1, ls_addr=0x80002008, wdata=0xDEADBEEF, wmask=0xFFFFFFFF
//      -> one ram_en cycle with ram_we=1 and the matching addr/data/mask;
//      ls_ack pulses; ls_rdata unchanged.
//   5. Reset asserted during WAIT -> next cycle busy=0, no ack, rdata=0;
//      a fresh if_req afterwards completes normally.
//   6. MEM_LAT=3: load request -> rdata captured at ISSUE+3; ls_ack at cycle N+5.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the IF/LS requesters, the arbiter and the RAM model.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req;
  logic              ls_we;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [DATA_W-1:0] ls_wmask;
  logic              ls_ack;
  logic [DATA_W-1:0] ls_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_wmask;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;
  logic              owner;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wmask, ram_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata, ram_en, ram_we, ram_addr,
           ram_wdata, ram_wmask, busy, owner
  );

  // Requester / RAM-model side
  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wmask, ram_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata, ram_en, ram_we, ram_addr,
           ram_wdata, ram_wmask, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port between instruction fetch and load/store.
// Transactions are serialised IDLE -> ISSUE -> WAIT -> RESP; LS has priority
// unless IF has been passed over STARVE_MAX times in a row.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic            clock,
  input  logic            reset,
  mem_port_arbiter_if.slave bus
);

  localparam int LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic [DATA_W-1:0] ram_wmask_q, ram_wmask_d;
  logic              if_ack_q, if_ack_d;
  logic              ls_ack_q, ls_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
  logic              grant_ls;

  // Next-state, arbitration and output register computation
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    we_d         = we_q;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    ram_wmask_d  = ram_wmask_q;
    if_ack_d     = 1'b0;
    ls_ack_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ls_rdata_d   = ls_rdata_q;
    // LS wins unless IF is pending and has already been passed over STARVE_MAX times.
    grant_ls     = bus.ls_req && !(bus.if_req && (starve_cnt_q == CNT_W'(STARVE_MAX)));

    case (state_q)
      IDLE: begin
        if (!bus.if_req) starve_cnt_d = '0;
        if (bus.if_req || bus.ls_req) begin
          state_d   = ISSUE;
          ram_en_d  = 1'b1;
          lat_cnt_d = '0;
          if (grant_ls) begin
            owner_d     = 1'b1;
            we_d        = bus.ls_we;
            ram_we_d    = bus.ls_we;
            ram_addr_d  = bus.ls_addr;
            ram_wdata_d = bus.ls_wdata;
            ram_wmask_d = bus.ls_wmask;
            if (bus.if_req) starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            // Fetches never write, so the write payload is cleared.
            owner_d      = 1'b0;
            we_d         = 1'b0;
            ram_addr_d   = bus.if_addr;
            ram_wdata_d  = '0;
            ram_wmask_d  = '0;
            starve_cnt_d = '0;
          end
        end
      end
      ISSUE: begin
        // The ISSUE cycle is latency cycle 0; WAIT begins at cycle 1.
        state_d   = WAIT;
        lat_cnt_d = LAT_W'(1);
      end
      WAIT: begin
        if (lat_cnt_q == LAT_W'(MEM_LAT)) begin
          state_d = RESP;
          if (owner_q) begin
            ls_ack_d = 1'b1;
            if (!we_q) ls_rdata_d = bus.ram_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.ram_rdata;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      ram_wmask_q  <= '0;
      if_ack_q     <= 1'b0;
      ls_ack_q     <= 1'b0;
      if_rdata_q   <= '0;
      ls_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_wmask_q  <= ram_wmask_d;
      if_ack_q     <= if_ack_d;
      ls_ack_q     <= ls_ack_d;
      if_rdata_q   <= if_rdata_d;
      ls_rdata_q   <= ls_rdata_d;
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.owner     = owner_q;
  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_wmask = ram_wmask_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;

endmodule
